// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the EXE stage: two-cycle multiplier and a restoring
// divider that retires one quotient bit per cycle, with pipeline stall handshake.
module mult_div_unit #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    input  logic        EXE_Wr,
    output logic        Busy,
    output logic        Result_Valid,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int CW = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   a_reg;
    logic [31:0]   b_reg;
    logic          unsigned_op;
    logic [31:0]   rem;
    logic [31:0]   quo;
    logic [31:0]   divisor;
    logic          neg_q;
    logic          neg_r;
    logic          div_zero;
    logic [CW-1:0] count;

    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [63:0]   product;
    logic [32:0]   shifted;
    logic [32:0]   diff;
    logic [31:0]   rem_next;
    logic [31:0]   quo_next;
    logic [31:0]   q_signed;
    logic [31:0]   r_signed;
    logic          last_iter;

    // Signed divide works on magnitudes; signs are reapplied on the last step.
    assign mag_a = (!Op[0] && A[31]) ? -A : A;
    assign mag_b = (!Op[0] && B[31]) ? -B : B;

    assign ext_a   = {unsigned_op ? 32'b0 : {32{a_reg[31]}}, a_reg};
    assign ext_b   = {unsigned_op ? 32'b0 : {32{b_reg[31]}}, b_reg};
    assign product = ext_a * ext_b;

    // Bit 32 of the trial subtraction is the borrow: set means restore.
    assign shifted   = {rem, quo[31]};
    assign diff      = shifted - {1'b0, divisor};
    assign rem_next  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_next  = {quo[30:0], ~diff[32]};
    assign q_signed  = neg_q ? -quo_next : quo_next;
    assign r_signed  = neg_r ? -rem_next : rem_next;
    assign last_iter = (count == CW'(DIV_ITER - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        Busy         = 1'b0;
        Result_Valid = 1'b0;
        case (state)
            IDLE: begin
                Busy = Start;
                if (Start) begin
                    state_next = Op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                Busy       = 1'b1;
                state_next = DONE;
            end
            DIV: begin
                Busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Result_Valid = 1'b1;
                if (EXE_Wr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides everything, including a same-cycle Start.
        if (Flush) begin
            state_next = IDLE;
            Busy       = 1'b0;
        end
        if (!resetn) begin
            Busy = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg       <= '0;
            b_reg       <= '0;
            unsigned_op <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_zero    <= 1'b0;
            count       <= '0;
            Hi          <= '0;
            Lo          <= '0;
        end else if (!Flush) begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg       <= A;
                        b_reg       <= B;
                        unsigned_op <= Op[0];
                        rem         <= '0;
                        quo         <= mag_a;
                        divisor     <= mag_b;
                        neg_q       <= !Op[0] && (A[31] ^ B[31]);
                        neg_r       <= !Op[0] && A[31];
                        div_zero    <= (B == 32'd0);
                        count       <= '0;
                    end
                end
                MUL: begin
                    Hi <= product[63:32];
                    Lo <= product[31:0];
                end
                DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        // Divide-by-zero keeps full latency but returns a fixed pattern.
                        if (div_zero) begin
                            Hi <= a_reg;
                            Lo <= 32'hFFFF_FFFF;
                        end else begin
                            Hi <= r_signed;
                            Lo <= q_signed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a transaction-level arithmetic model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_mult_div_unit;

    localparam int DIV_ITER = 32;

    logic        clk;
    logic        resetn;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        EXE_Wr;
    logic        Busy;
    logic        Result_Valid;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int assertCount = 0;
    int failCount   = 0;

    int          left    = 0;
    logic        mValid  = 1'b0;
    logic [31:0] mHi     = '0;
    logic [31:0] mLo     = '0;
    logic [31:0] pendHi  = '0;
    logic [31:0] pendLo  = '0;

    mult_div_unit #(.DIV_ITER(DIV_ITER)) dut (
        .clk(clk),
        .resetn(resetn),
        .Start(Start),
        .Op(Op),
        .A(A),
        .B(B),
        .Flush(Flush),
        .EXE_Wr(EXE_Wr),
        .Busy(Busy),
        .Result_Valid(Result_Valid),
        .Hi(Hi),
        .Lo(Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain arithmetic reference: {Hi, Lo} for any operation.
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint p;
        longint q;
        longint r;
        if (op[0]) begin
            x = {32'b0, a};
            y = {32'b0, b};
        end else begin
            x = {{32{a[31]}}, a};
            y = {{32{b[31]}}, b};
        end
        if (!op[1]) begin
            p = x * y;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: counts remaining work cycles and commits the computed result when done.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            left   <= 0;
            mValid <= 1'b0;
            mHi    <= '0;
            mLo    <= '0;
        end else if (Flush) begin
            left   <= 0;
            mValid <= 1'b0;
        end else if (mValid) begin
            if (EXE_Wr) mValid <= 1'b0;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) begin
                mValid <= 1'b1;
                mHi    <= pendHi;
                mLo    <= pendLo;
            end
        end else if (Start) begin
            {pendHi, pendLo} <= refResult(Op, A, B);
            left <= Op[1] ? DIV_ITER : 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    task automatic compareLoop();
        logic expBusy;
        forever begin
            @(negedge clk);
            expBusy = resetn && !Flush && ((left == 0 && !mValid && Start) || left > 0);
            checkOutput("busy", {31'b0, Busy}, {31'b0, expBusy});
            checkOutput("valid", {31'b0, Result_Valid}, {31'b0, mValid});
            checkOutput("hi", Hi, mHi);
            checkOutput("lo", Lo, mLo);
        end
    endtask

    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        Start  = 1'b1;
        Op     = op;
        A      = a;
        B      = b;
        EXE_Wr = 1'b0;
    endtask

    // Issue an operation, scramble operands afterwards, and count busy cycles until the result.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int busyCycles);
        bit done;
        done       = 1'b0;
        busyCycles = 0;
        startOp(op, a, b);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (Result_Valid) begin
                done = 1'b1;
            end else begin
                if (Busy) busyCycles++;
                @(posedge clk);
                #1;
                A  = $urandom;
                B  = $urandom;
                Op = 2'($urandom);
            end
        end
        if (!done) checkOutput("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic commitResult();
        @(posedge clk);
        #1;
        Start  = 1'b0;
        EXE_Wr = 1'b1;
        @(posedge clk);
        #1;
        EXE_Wr = 1'b0;
    endtask

    task automatic runAndCheck(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                               input int expBusy);
        int n;
        applyStimulus(op, a, b, n);
        checkOutput({name, "_busy"}, 32'(n), 32'(expBusy));
        checkOutput({name, "_hi"}, Hi, expHi);
        checkOutput({name, "_lo"}, Lo, expLo);
        commitResult();
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        Start  = 1'b0;
        Op     = 2'b00;
        A      = '0;
        B      = '0;
        Flush  = 1'b0;
        EXE_Wr = 1'b0;
        fork
            compareLoop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, Busy}, 32'd0);
        checkOutput("rst_valid", {31'b0, Result_Valid}, 32'd0);
        checkOutput("rst_hi", Hi, 32'd0);
        checkOutput("rst_lo", Lo, 32'd0);
        #1;
        resetn = 1'b1;

        runAndCheck("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
        runAndCheck("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_ITER + 1);
        runAndCheck("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_ITER + 1);
        runAndCheck("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_ITER + 1);
        runAndCheck("div_zero_neg", 2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, DIV_ITER + 1);
        runAndCheck("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_ITER + 1);
        runAndCheck("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
        runAndCheck("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2);

        // Result held while the pipeline stalls; Start stays high without restarting.
        applyStimulus(2'b11, 32'd7, 32'd2, n);
        checkOutput("divu_busy", 32'(n), 32'(DIV_ITER + 1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            A = 32'(i * 13 + 1);
            @(negedge clk);
            checkOutput("stall_valid", {31'b0, Result_Valid}, 32'd1);
            checkOutput("stall_hi", Hi, 32'd1);
            checkOutput("stall_lo", Lo, 32'd3);
        end
        commitResult();
        @(negedge clk);
        checkOutput("commit_valid", {31'b0, Result_Valid}, 32'd0);
        checkOutput("commit_busy", {31'b0, Busy}, 32'd0);

        // Flush at divide cycle 10 abandons the operation and keeps the old result.
        startOp(2'b10, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        Flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_busy", {31'b0, Busy}, 32'd0);
        @(posedge clk);
        #1;
        Flush = 1'b0;
        Start = 1'b0;
        @(negedge clk);
        checkOutput("post_flush_busy", {31'b0, Busy}, 32'd0);
        checkOutput("post_flush_valid", {31'b0, Result_Valid}, 32'd0);
        checkOutput("post_flush_hi", Hi, 32'd1);
        checkOutput("post_flush_lo", Lo, 32'd3);
        runAndCheck("multu_4x5", 2'b01, 32'd4, 32'd5, 32'd0, 32'd20, 2);

        // Reset in the middle of a divide clears outputs immediately.
        startOp(2'b10, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'b0, Busy}, 32'd0);
        checkOutput("midrst_valid", {31'b0, Result_Valid}, 32'd0);
        checkOutput("midrst_hi", Hi, 32'd0);
        checkOutput("midrst_lo", Lo, 32'd0);
        Start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        runAndCheck("div_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, DIV_ITER + 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter DIV_ITER, default 32, meaning the number of divider iteration cycles (one quotient bit per cycle).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Start, input, 1, EXE-stage mult/div instruction present.
REQ-005 SHALL have port Op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports A and B, input, 32 each, rs/rt operands; for DIV/DIVU, A is the dividend and B is the divisor.
REQ-007 SHALL have port Flush, input, 1, exception/EXE flush; aborts any operation.
REQ-008 SHALL have port EXE_Wr, input, 1, EXE pipeline register write enable from pipeline control.
REQ-009 SHALL have port Busy, output, 1, the DIVMULTBusy stall request to pipeline control.
REQ-010 SHALL have port Result_Valid, output, 1, Hi/Lo hold a completed result.
REQ-011 SHALL have ports Hi and Lo, output, 32 each, result: MULT gives high/low product; DIV gives remainder/quotient.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-013 SHALL accept an operation in IDLE when Start=1 and Flush=0, latching A, B and Op.
  - Op[1]=0 -> MUL.
  - Op[1]=1 -> DIV.
REQ-014 SHALL drive Busy combinationally as ((IDLE & Start) | MUL | DIV) & ~Flush, so the accept cycle already stalls.
REQ-015 SHALL complete MUL in 2 cycles: accept cycle is cycle 0, Busy is high in cycles 0-1, and DONE is entered at cycle 2.
  - MULT: signed 64-bit product.
  - MULTU: unsigned 64-bit product.
  - Product split as {Hi,Lo}.
REQ-016 SHALL run DIV as a restoring divider on operand magnitudes, one bit per cycle for DIV_ITER cycles.
  - Busy is high in cycles 0..DIV_ITER.
  - DONE is entered at cycle DIV_ITER+1.
REQ-017 SHALL apply signed-division sign rules: quotient sign = sign(A) xor sign(B); remainder sign = sign(A); DIVU treats both operands as unsigned.
REQ-018 SHALL, for divisor zero, keep the same latency and produce Hi=A, Lo=32'hFFFFFFFF.
REQ-019 SHALL produce Lo=32'h80000000, Hi=0 for DIV 32'h80000000 / 32'hFFFFFFFF.
REQ-020 SHALL in DONE assert Result_Valid=1, Busy=0, hold Hi/Lo stable, and ignore Start.
  - DONE -> IDLE on EXE_Wr=1.
  - Remain in DONE while EXE_Wr=0, covering stalls from other sources.
REQ-021 SHALL, on Flush=1 in any state, go to IDLE next cycle.
  - Result_Valid goes low.
  - No result is committed; Hi/Lo keep their previous values.
  - Flush takes priority over Start in the same cycle.
REQ-022 SHALL ignore changes on A, B and Op after acceptance.
REQ-023 SHALL keep Result_Valid=0 in IDLE, MUL and DIV.

Reset
REQ-024 SHALL on resetn=0 immediately enter IDLE, with Busy=0, Result_Valid=0, Hi=0, Lo=0, and iteration counter=0.
REQ-025 SHALL, on reset during MUL or DIV, discard the operation; after release, the next Start begins a fresh operation.

Verification
REQ-026 SHALL cover MULT A=32'hFFFFFFFE (-2), B=3.
  - Busy high 2 cycles.
  - Then Result_Valid=1, Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFA.
REQ-027 SHALL cover DIV A=-7, B=2.
  - Busy high 33 cycles.
  - Then Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1).
  - DIVU A=7, B=2 -> Lo=3, Hi=1.
REQ-028 SHALL cover DIVU A=5, B=0 -> after 33 busy cycles Hi=5, Lo=32'hFFFFFFFF.
REQ-029 SHALL cover Flush=1 at DIV cycle 10.
  - Next cycle IDLE, Busy=0, Result_Valid=0.
  - Hi/Lo unchanged.
  - A following MULTU 4*5 gives Lo=20, Hi=0.
REQ-030 SHALL cover result ready with EXE_Wr=0 for 5 cycles.
  - Result_Valid stays 1 with Hi/Lo stable.
  - Start stays high without restarting.
  - EXE_Wr=1 -> IDLE next cycle.
REQ-031 SHALL cover resetn=0 at DIV cycle 20.
  - Outputs immediately zero.
  - After release, DIV 100/7 gives Lo=14, Hi=2.
